// File: rtl/input_frame_buffer_pkg.sv
// rtl/input_frame_buffer_pkg.sv - shared constants and helpers for the input frame buffer
package input_frame_buffer_pkg;

    localparam int IFB_DATA_WIDTH = 32;
    localparam int IFB_DEPTH      = 48;
    localparam int IFB_LANES      = 1;
    localparam int IFB_CNT_WIDTH  = 16;

    // Ceiling log2, usable in parameter expressions; bounded loop keeps it synthesizable.
    function automatic int ifb_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/input_frame_buffer_if.sv
// rtl/input_frame_buffer_if.sv - beat input and frame output handshakes of the input frame buffer
interface input_frame_buffer_if
    import input_frame_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = IFB_DATA_WIDTH,
    parameter int DEPTH      = IFB_DEPTH,
    parameter int LANES      = IFB_LANES
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [DEPTH*DATA_WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/input_frame_buffer_hold.sv
// rtl/input_frame_buffer_hold.sv - load-enabled frame hold register with async active-low reset
module frame_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;
endmodule

// File: rtl/input_frame_buffer.sv
// rtl/input_frame_buffer.sv - gathers LANES-wide beats into a DEPTH-word frame and hands it off
module input_frame_buffer
    import input_frame_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = IFB_DATA_WIDTH,
    parameter int DEPTH      = IFB_DEPTH,
    parameter int LANES      = IFB_LANES,
    parameter int CNT_WIDTH  = IFB_CNT_WIDTH,
    localparam int BEATS     = DEPTH / LANES,
    localparam int FILL_W    = ifb_clog2(BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input_frame_buffer_if.slave   bus,
    output logic [FILL_W-1:0]     o_fill_level,
    output logic [CNT_WIDTH-1:0]  o_frame_count
);
    localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(BEATS);

    generate
        if (LANES < 1 || (DEPTH % LANES) != 0) begin : g_bad_cfg
            $error("input_frame_buffer: DEPTH must be a positive multiple of LANES");
        end
    endgenerate

    logic [FILL_W-1:0]           r_fill_level;
    logic                        r_out_valid;
    logic [CNT_WIDTH-1:0]        r_frame_count;
    logic [DEPTH*DATA_WIDTH-1:0] r_bank;

    logic w_full;
    logic w_accept;
    logic w_xfer;
    logic w_out_hs;
    logic w_load;
    logic [DEPTH*DATA_WIDTH-1:0] w_hold_data;

    assign w_full   = (r_fill_level == FULL_LVL);
    assign w_accept = bus.in_valid && !w_full;
    assign w_xfer   = w_full && (!r_out_valid || bus.out_ready);
    assign w_out_hs = r_out_valid && bus.out_ready;
    // clear wins over transfer, so the hold stage keeps its last frame
    assign w_load   = w_xfer && !i_clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill_level  <= '0;
            r_out_valid   <= 1'b0;
            r_frame_count <= '0;
            r_bank        <= '0;
        end else if (i_clear) begin
            r_fill_level  <= '0;
            r_out_valid   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_accept) begin
                for (int b = 0; b < BEATS; b++) begin
                    for (int j = 0; j < LANES; j++) begin
                        if (r_fill_level == FILL_W'(b)) begin
                            r_bank[(b*LANES+j)*DATA_WIDTH +: DATA_WIDTH] <=
                                bus.in_data[j*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                r_fill_level <= r_fill_level + FILL_W'(1);
            end
            // a transfer on the handshake edge keeps out_valid high for back-to-back frames
            if (w_xfer) begin
                r_fill_level <= '0;
                r_out_valid  <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid  <= 1'b0;
            end
            if (w_out_hs) begin
                r_frame_count <= r_frame_count + CNT_WIDTH'(1);
            end
        end
    end

    frame_hold_reg #(
        .WIDTH (DEPTH*DATA_WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (r_bank),
        .o_data (w_hold_data)
    );

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = w_hold_data;
    assign o_fill_level  = r_fill_level;
    assign o_frame_count = r_frame_count;
endmodule

// File: doc/input_frame_buffer.md
INPUT_FRAME_BUFFER -- requirements
Module: input_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per word.
REQ-002 SHALL have parameter DEPTH, default 48, words per frame.
REQ-003 SHALL have parameter LANES, default 1, words accepted per input beat; DEPTH SHALL be an integer multiple of LANES, with BEATS = DEPTH/LANES.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, frame counter width.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 clear  input  1  synchronous flush of partial frame and hold stage.
REQ-008 in_valid  input  1  in_data beat valid.
REQ-009 in_ready  output  1  block can accept a beat.
REQ-010 in_data  input  LANES*DATA_WIDTH  lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-011 out_valid  output  1  complete frame held on out_data.
REQ-012 out_ready  input  1  consumer takes frame.
REQ-013 out_data  output  DEPTH*DATA_WIDTH  word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 fill_level  output  clog2(BEATS+1)  beats accepted into current partial frame.
REQ-015 frame_count  output  CNT_WIDTH  frames delivered (out handshakes) since reset/clear.

Function
REQ-016 Beat accepted iff in_valid && in_ready at a rising edge; lane j of beat b (0-based within frame) SHALL land in fill word b*LANES+j.
REQ-017 in_ready SHALL equal (fill_level < BEATS); purely combinational from registered state, no dependence on in_valid.
REQ-018 fill_level SHALL increment by 1 per accepted beat and saturate at BEATS (full) until transfer.
REQ-019 Transfer SHALL occur at an edge where fill_level == BEATS && (!out_valid || out_ready): hold register <= fill bank, out_valid <= 1, fill_level <= 0.
REQ-020 Latency: last beat accepted at edge N -> out_valid high after edge N+1 if hold stage free; stalls further while hold stage occupied and out_ready low.
REQ-021 Out handshake out_valid && out_ready at an edge SHALL clear out_valid unless a transfer occurs on the same edge, in which case out_valid stays 1 with new data (back-to-back frames, no bubble).
REQ-022 Throughput: with out_ready held 1, continuous in_valid SHALL sustain BEATS accepted beats per BEATS+1 cycles (one full-state cycle per frame).
REQ-023 out_data SHALL be stable while out_valid && !out_ready, and retain last frame when out_valid = 0.
REQ-024 frame_count SHALL increment on each out handshake, wrapping 2^CNT_WIDTH-1 -> 0.
REQ-025 clear SHALL, at the edge, set fill_level = 0, out_valid = 0, frame_count = 0; clear has priority over accept, transfer and out handshake on the same edge; data registers unchanged.
REQ-026 in_valid when in_ready = 0 SHALL have no effect; the producer holds the beat.

Reset
REQ-027 rst low SHALL asynchronously force fill_level = 0, out_valid = 0, frame_count = 0, fill bank and out_data = 0; in_ready = 1 follows.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; first beat after release is word 0..LANES-1 of a new frame.

Structure
REQ-029 Shared package SHALL hold the clog2 constant function and default DATA_WIDTH/DEPTH/LANES constants used by the TCU cut_io_interface.
REQ-030 Hold stage SHALL be a sub-module frame_hold_reg (load-enabled DEPTH*DATA_WIDTH register, async active-low reset to 0); fill bank, counters and control in input_frame_buffer.
REQ-031 Elaboration SHALL fail if DEPTH % LANES != 0 or LANES < 1.

Verification
REQ-032 DEPTH=4, LANES=1, out_ready=1: send 1,2,3,4 on consecutive cycles -> out_valid one cycle after 4th accept, out_data words = {1,2,3,4} at k=0..3, frame_count=1.
REQ-033 DEPTH=4, LANES=2: beats {lane0=A,lane1=B},{C,D} -> words 0..3 = A,B,C,D; fill_level 0->1->2->0.
REQ-034 out_ready=0, send two full frames -> first frame held, second fills, in_ready=0 with fill_level=BEATS; raise out_ready one cycle -> frame 1 consumed, frame 2 appears next edge with out_valid continuously 1.
REQ-035 Mid-frame (fill_level=2) assert clear with in_valid=1 -> fill_level=0, beat not captured, out_valid=0, frame_count=0.
REQ-036 Mid-frame async rst pulse between edges -> all outputs 0 immediately; next frame 5,6,7,8 delivered correctly.
REQ-037 CNT_WIDTH=2: deliver 5 frames -> frame_count sequence 1,2,3,0,1.
